// File: rtl/os_fifo_pkg.sv
// os_pkg: shared widths, bit positions and word type for the output-storage FIFO
package os_pkg;
  localparam int OS_REC_W = 35;
  localparam int OS_BX_W = 12;
  localparam int OS_AW = 4;
  localparam int OS_W = 49;
  localparam int OS_EMPTY_B = 48;
  localparam int OS_OVF_B = 47;
  typedef struct packed {
    logic [OS_BX_W-1:0] bx;
    logic [OS_REC_W-1:0] rec;
  } os_word_t;
endpackage

// File: rtl/os_fifo_sync_rise.sv
// sync_rise: 2-flop synchroniser plus edge flop; clk, rst (sync, active-high), d async in, q one-cycle rising-edge pulse
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {d, s1, s2};
  end
  assign q = s2 & ~s3;
endmodule

// File: rtl/os_fifo.sv
// os_fifo: BX-stamped FWFT FIFO feeding the TAP OS read port; clk, rst, bc0, os_we, os_rec in, OSre (tck domain) pops, OS = {empty, ovf, bx, rec} of head, os_count words stored
module os_fifo
  import os_pkg::*;
#(
  parameter int REC_W = OS_REC_W,
  parameter int BX_W = OS_BX_W,
  parameter int AW = OS_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bc0,
  input  logic                  os_we,
  input  logic [REC_W-1:0]      os_rec,
  input  logic                  OSre,
  output logic [BX_W+REC_W+1:0] OS,
  output logic [AW:0]           os_count
);
  logic [BX_W-1:0] bx;
  logic [AW:0] wp, rp;
  logic [BX_W+REC_W-1:0] mem [2**AW];
  logic pop, empty, full, do_pop, do_push, ovf;
  sync_rise u_sync (.clk(clk), .rst(rst), .d(OSre), .q(pop));
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  // a pop on a full cycle frees the slot the push needs
  assign do_push = os_we & (~full | do_pop);
  assign os_count = wp - rp;
  assign OS = empty ? {1'b1, ovf, {(BX_W+REC_W){1'b0}}} : {1'b0, ovf, mem[rp[AW-1:0]]};
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= {bx, os_rec};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bx <= '0;
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
    end else begin
      bx <= bc0 ? '0 : bx + 1'b1;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      if (os_we & full & ~pop) ovf <= 1'b1;
      else if (do_pop & ~do_push & (os_count == (AW+1)'(1))) ovf <= 1'b0;
    end
  end
endmodule
